// File: rtl/fifo_wreq_pkg.sv
// Shared widths and FSM state type for the FIFO write-request burst engine.
package fifo_wreq_pkg;

  localparam int unsigned ADDRSIZE = 10;
  localparam int unsigned DATASIZE = 8;
  localparam int unsigned REM_W    = ADDRSIZE + 1;
  localparam int unsigned TMR_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    STALL = 3'd4
  } wreq_state_t;

endpackage

// File: rtl/wreq_cnt.sv
// Loadable saturating down-counter with zero flag.
module wreq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fifo_wreq.sv
// Burst write requester: handshakes with the FIFO arbiter, then streams an
// incrementing data pattern with optional inter-word gaps and full backpressure.
module fifo_wreq
  import fifo_wreq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                start,
  input  logic [ADDRSIZE:0]   burst_len,
  input  logic [1:0]          widle,
  input  logic [DATASIZE-1:0] data_seed,
  input  logic                wack,
  input  logic                wfull,
  output logic                wen,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic [ADDRSIZE-1:0] wptr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [TMR_W-1:0] TMO    = TMR_W'(ACK_TIMEOUT);
  localparam bit               TMO_EN = (ACK_TIMEOUT != 0);

  wreq_state_t         r_state;
  logic                r_wen;
  logic                r_winc;
  logic                r_done;
  logic                r_err;
  logic [DATASIZE-1:0] r_wdata;
  logic [DATASIZE-1:0] r_next_data;
  logic [ADDRSIZE-1:0] r_wptr;
  logic [1:0]          r_widle;

  logic                w_start;
  logic                w_timeout;
  logic                w_write;
  logic                w_last;
  logic                w_gap_end;
  logic                w_rem_load;
  logic                w_rem_dec;
  logic                w_rem_zero;
  logic [REM_W-1:0]    w_rem_cnt;
  logic                w_tmr_load;
  logic                w_tmr_dec;
  logic                w_tmr_zero;
  logic [TMR_W-1:0]    w_tmr_val;
  logic [TMR_W-1:0]    w_tmr_cnt;

  // Decode of the current cycle's events and counter controls.
  always_comb begin
    w_start    = 1'b0;
    w_timeout  = 1'b0;
    w_write    = 1'b0;
    w_last     = 1'b0;
    w_gap_end  = 1'b0;
    w_tmr_dec  = 1'b0;

    w_start   = (r_state == IDLE) && start;
    w_timeout = (r_state == REQ) && !wack && TMO_EN && (w_tmr_cnt == TMR_W'(1));
    w_write   = (r_state == XFER) && !w_rem_zero && !wfull;
    w_last    = w_write && (w_rem_cnt == REM_W'(1));
    w_gap_end = (r_state == GAP) && (w_tmr_zero || (w_tmr_cnt == TMR_W'(1)));

    // The timer is shared: ack timeout while in REQ, gap length while in GAP.
    w_rem_load = w_start;
    w_rem_dec  = w_write;
    w_tmr_load = w_start || (w_write && !w_last && (r_widle != 2'd0));
    w_tmr_val  = w_start ? TMO : TMR_W'(r_widle);
    w_tmr_dec  = ((r_state == REQ) && !wack && TMO_EN) || (r_state == GAP);
  end

  wreq_cnt #(.W(REM_W)) u_rem_cnt (
    .clk        (wclk),
    .rst_n      (wrst_n),
    .i_load     (w_rem_load),
    .i_load_val (burst_len),
    .i_dec      (w_rem_dec),
    .o_cnt      (w_rem_cnt),
    .o_zero     (w_rem_zero)
  );

  wreq_cnt #(.W(TMR_W)) u_tmr_cnt (
    .clk        (wclk),
    .rst_n      (wrst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_cnt      (w_tmr_cnt),
    .o_zero     (w_tmr_zero)
  );

  // FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= IDLE;
      r_wen       <= 1'b0;
      r_winc      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wdata     <= '0;
      r_next_data <= '0;
      r_wptr      <= '0;
      r_widle     <= '0;
    end else begin
      r_winc <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_widle     <= widle;
            r_next_data <= data_seed;
            r_wen       <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (wack) begin
            r_wen   <= 1'b0;
            r_state <= XFER;
          end else if (w_timeout) begin
            r_wen   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        XFER: begin
          // Remaining count hit zero on the previous word: report completion.
          if (w_rem_zero) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (wfull) begin
            r_state <= STALL;
          end else begin
            r_winc      <= 1'b1;
            r_wdata     <= r_next_data;
            r_next_data <= r_next_data + DATASIZE'(1);
            r_wptr      <= r_wptr + ADDRSIZE'(1);
            if (!w_last && (r_widle != 2'd0)) begin
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (w_gap_end) begin
            r_state <= XFER;
          end
        end
        STALL: begin
          if (!wfull) begin
            r_state <= XFER;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wen   = r_wen;
  assign winc  = r_winc;
  assign wdata = r_wdata;
  assign wptr  = r_wptr;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state != IDLE);

endmodule
